selector_sequencer: RTL
=======================

// Module: selector_sequencer
// PURPOSE
//   Sequencer for the display selector: drives its one-hot 4-bit select so the 8-bit output
//   steps through operand A, operand B, opcode and result Y.
//   Auto mode: dwell timer advances the sequence. Manual mode: step pulses advance it.
//   A result_valid pulse from the ALU jumps straight to the result view.
//   Sits between the ALU control and the selector.
// PARAMETERS
//   DWELL   16                 cycles each view is held in auto mode (>=2)
//   CNT_W   $clog2(DWELL)      dwell counter width
// PORTS
//   clk           in   1  system clock; all state updates on rising edge
//   rst           in   1  synchronous, active-high reset
//   en            in   1  1 = sequencing active; 0 = blank output (IDLE)
//   mode          in   1  0 = auto (dwell timer), 1 = manual (step)
//   step          in   1  single-cycle advance request; used only in manual mode
//   result_valid  in   1  single-cycle pulse: new Y available
//   select        out  4  one-hot to selector: [0]=A [1]=B [2]=Y [3]=opcode; 0000 = blank
//   phase         out  2  encoded view: 0=A 1=B 2=OP 3=Y; 0 in IDLE
//   active        out  1  1 when not IDLE
//   frame_done    out  1  1-cycle pulse on Y->A wrap
// BEHAVIOUR
//   - One clock, rst synchronous active-high. All outputs registered.
//   - Reset values: select=0000, phase=0, active=0, frame_done=0, dwell counter=0, state=IDLE.
//   - States: IDLE, SHOW_A, SHOW_B, SHOW_OP, SHOW_Y.
//   - Sequence order: A -> B -> OP -> Y -> A.
//   - select encoding:
//       A  = 0001
//       B  = 0010
//       OP = 1000
//       Y  = 0100
//       IDLE = 0000
//   - Exactly one select bit high outside IDLE; never two.
//   - Priority per cycle, highest first: rst > en=0 > result_valid > advance (dwell expiry or step).
//   - IDLE -> SHOW_A the cycle after en=1 is sampled; counter=0.
//   - en=0 in any state: next cycle IDLE, select=0000, counter=0. frame_done not pulsed.
//   - Auto advance (mode=0):
//       - counter increments every cycle in a SHOW state.
//       - When counter==DWELL-1, the next cycle moves to the next state with counter=0.
//       - Each view is therefore visible exactly DWELL cycles.
//       - step is ignored.
//   - Manual advance (mode=1):
//       - Counter is held at 0.
//       - step=1 sampled -> next state on the following cycle.
//       - A step held high advances once per cycle.
//   - Mode change: counter cleared on the cycle the new mode is sampled; state unchanged.
//   - result_valid in any SHOW state, including SHOW_Y:
//       - next cycle SHOW_Y, counter=0; Y then holds a full DWELL (auto mode).
//       - No frame_done pulse.
//       - Ignored in IDLE.
//   - frame_done=1 in exactly the first cycle of SHOW_A that follows SHOW_Y via normal advance.
//       - Not pulsed on IDLE->A or after reset.
//   - Latency: input sampled at edge N -> select/phase change visible after edge N+1 (1 cycle).
//   - Reset mid-sequence: abandons the view immediately. Next cycle outputs are reset values,
//     regardless of step/result_valid.
// STRUCTURE
//   - Shared package selector_pkg holds:
//       - state enum localparams (ST_IDLE..ST_SHOW_Y)
//       - one-hot select constants (SEL_A=4'b0001, SEL_B=4'b0010, SEL_Y=4'b0100,
//         SEL_OP=4'b1000, SEL_NONE=4'b0000)
//       - phase codes
//   - Sub-module dwell_counter (CNT_W, DWELL) provides:
//       - inputs: clear, inc
//       - output: expire (counter==DWELL-1)
//   - Top level: FSM plus registered output decode.
// TESTING (bench with DWELL=4)
//   1. rst=1 for 2 cycles with en=1, step=1 -> select=0000, phase=0, active=0, frame_done=0.
//   2. en=1, mode=0, 20 cycles -> select:
//        - 0001 x4, 0010 x4, 1000 x4, 0100 x4
//        - then 0001 with frame_done=1 for one cycle only.
//   3. mode=1, no step for 12 cycles -> select stays 0001; three step pulses ->
//      0010, 1000, 0100, each one cycle after its step.
//   4. result_valid in 2nd cycle of SHOW_A -> next cycle 0100 for 4 cycles, then 0001 with frame_done=1;
//      second result_valid during SHOW_Y -> Y held 4 cycles from the pulse.
//   5. en=0 in SHOW_B -> next cycle 0000, active=0; en=1 again -> 0001 after 1 cycle, held 4 cycles, frame_done=0.
//   6. Same-cycle rst=1, step=1, result_valid=1 in SHOW_OP -> reset values next cycle;
//      same-cycle en=0 and result_valid=1 -> 0000.

Source files
------------

// File: rtl/selector_pkg.sv
// Shared types and constants for the display selector sequencer.
// Views, one-hot selector codes and phase encodings.
package selector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_A,
        ST_SHOW_B,
        ST_SHOW_OP,
        ST_SHOW_Y
    } state_t;

    localparam logic [3:0] SEL_A    = 4'b0001;
    localparam logic [3:0] SEL_B    = 4'b0010;
    localparam logic [3:0] SEL_Y    = 4'b0100;
    localparam logic [3:0] SEL_OP   = 4'b1000;
    localparam logic [3:0] SEL_NONE = 4'b0000;

    localparam logic [1:0] PH_A  = 2'd0;
    localparam logic [1:0] PH_B  = 2'd1;
    localparam logic [1:0] PH_OP = 2'd2;
    localparam logic [1:0] PH_Y  = 2'd3;

    function automatic logic [3:0] sel_of(input state_t s);
        logic [3:0] r;
        r = SEL_NONE;
        unique case (s)
            ST_SHOW_A:  r = SEL_A;
            ST_SHOW_B:  r = SEL_B;
            ST_SHOW_OP: r = SEL_OP;
            ST_SHOW_Y:  r = SEL_Y;
            default:    r = SEL_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] phase_of(input state_t s);
        logic [1:0] r;
        r = PH_A;
        unique case (s)
            ST_SHOW_B:  r = PH_B;
            ST_SHOW_OP: r = PH_OP;
            ST_SHOW_Y:  r = PH_Y;
            default:    r = PH_A;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/selector_sequencer_dwell.sv
// Dwell timer: counts cycles spent in one view.
// Clear has priority over increment; expire flags the last dwell cycle.
module dwell_counter #(
    parameter int DWELL = 16,
    parameter int CNT_W = $clog2(DWELL)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    // Counter register: clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/selector_sequencer.sv
// Sequencer driving the one-hot display selector through A, B, OP, Y.
// Auto mode advances on dwell expiry, manual mode on step pulses.
module selector_sequencer
    import selector_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int CNT_W = $clog2(DWELL)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       step,
    input  logic       result_valid,
    output logic [3:0] select,
    output logic [1:0] phase,
    output logic       active,
    output logic       frame_done
);

    state_t state;
    state_t next_state;
    logic   mode_q;
    logic   expire;
    logic   advance;
    logic   clear;
    logic   inc;
    logic   wrap;

    dwell_counter #(
        .DWELL(DWELL),
        .CNT_W(CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (inc),
        .expire(expire)
    );

    // Next-state and counter control, priority en > result_valid > advance.
    always_comb begin
        next_state = state;
        advance    = mode ? step : expire;
        clear      = 1'b0;
        inc        = 1'b0;
        wrap       = 1'b0;
        if (!en) begin
            next_state = ST_IDLE;
            clear      = 1'b1;
        end else if (state == ST_IDLE) begin
            next_state = ST_SHOW_A;
            clear      = 1'b1;
        end else if (result_valid) begin
            next_state = ST_SHOW_Y;
            clear      = 1'b1;
        end else if (advance) begin
            clear = 1'b1;
            unique case (state)
                ST_SHOW_A:  next_state = ST_SHOW_B;
                ST_SHOW_B:  next_state = ST_SHOW_OP;
                ST_SHOW_OP: next_state = ST_SHOW_Y;
                ST_SHOW_Y: begin
                    next_state = ST_SHOW_A;
                    wrap       = 1'b1;
                end
                default:    next_state = ST_IDLE;
            endcase
        end else begin
            clear = mode || (mode != mode_q);
            inc   = !mode;
        end
    end

    // State, mode history and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= 1'b0;
            select     <= SEL_NONE;
            phase      <= PH_A;
            active     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            mode_q     <= mode;
            select     <= sel_of(next_state);
            phase      <= phase_of(next_state);
            active     <= (next_state != ST_IDLE);
            frame_done <= wrap;
        end
    end

endmodule
